// File: rtl/registro_universal_n.sv
// registro_universal_n: N-bit universal shift register with parallel load,
// left/right shift with per-direction serial inputs, hold, and a saturating
// shift counter that flags a fully serialised word.
// Optional build macro ROTACION_EN: modo 11 rotates (direction from s_in_der)
// instead of holding.
module registro_universal_n #(
  parameter  int unsigned N  = 4,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enb,
  input  logic [1:0]    modo,
  input  logic [N-1:0]  usual,
  input  logic          s_in_izq,
  input  logic          s_in_der,
  output logic [N-1:0]  q,
  output logic          s_out_izq,
  output logic          s_out_der,
  output logic [CW-1:0] cuenta,
  output logic          listo
);

  localparam logic [1:0] MODO_CARGA = 2'b00;
  localparam logic [1:0] MODO_IZQ   = 2'b01;
  localparam logic [1:0] MODO_DER   = 2'b10;
  localparam logic [1:0] MODO_ESP   = 2'b11;

  localparam logic [CW-1:0] CUENTA_MAX = CW'(N);

  logic [N-1:0]  q_sig;
  logic [CW-1:0] cuenta_sig;
  logic [CW-1:0] cuenta_inc;
  logic          desplaza;

  // Counter increment that saturates at N rather than wrapping.
  assign cuenta_inc = (cuenta == CUENTA_MAX) ? cuenta : cuenta + CW'(1);

  // Next-state selection for the data register and shift counter.
  always_comb begin
    q_sig      = q;
    cuenta_sig = cuenta;
    desplaza   = 1'b0;
    if (enb) begin
      unique case (modo)
        MODO_CARGA: begin
          q_sig      = usual;
          cuenta_sig = '0;
        end
        MODO_IZQ: begin
          q_sig    = {q[N-2:0], s_in_der};
          desplaza = 1'b1;
        end
        MODO_DER: begin
          q_sig    = {s_in_izq, q[N-1:1]};
          desplaza = 1'b1;
        end
        MODO_ESP: begin
`ifdef ROTACION_EN
          if (s_in_der) begin
            q_sig = {q[N-2:0], q[N-1]};
          end else begin
            q_sig = {q[0], q[N-1:1]};
          end
          desplaza = 1'b1;
`else
          q_sig = q;
`endif
        end
        default: q_sig = q;
      endcase
      if (desplaza) begin
        cuenta_sig = cuenta_inc;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= '0;
      cuenta <= '0;
    end else begin
      q      <= q_sig;
      cuenta <= cuenta_sig;
    end
  end

  // Serial taps and word-complete flag are decoded straight from state.
  assign s_out_izq = q[N-1];
  assign s_out_der = q[0];
  assign listo     = (cuenta == CUENTA_MAX);

endmodule

// File: tb/tb_registro_universal_n.sv
// Directed self-checking bench for registro_universal_n at N=4 and N=8.
module tb_registro_universal_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned pruebas = 0;
  int unsigned fallos  = 0;

  // N=4 instance signals
  logic       reset4, enb4, sizq4, sder4;
  logic [1:0] modo4;
  logic [3:0] usual4, q4;
  logic       oizq4, oder4, listo4;
  logic [2:0] cuenta4;

  // N=8 instance signals
  logic       reset8, enb8, sizq8, sder8;
  logic [1:0] modo8;
  logic [7:0] usual8, q8;
  logic       oizq8, oder8, listo8;
  logic [3:0] cuenta8;

  registro_universal_n #(.N(4)) dut4 (
    .clk(clk), .reset(reset4), .enb(enb4), .modo(modo4), .usual(usual4),
    .s_in_izq(sizq4), .s_in_der(sder4), .q(q4), .s_out_izq(oizq4),
    .s_out_der(oder4), .cuenta(cuenta4), .listo(listo4)
  );

  registro_universal_n #(.N(8)) dut8 (
    .clk(clk), .reset(reset8), .enb(enb8), .modo(modo8), .usual(usual8),
    .s_in_izq(sizq8), .s_in_der(sder8), .q(q8), .s_out_izq(oizq8),
    .s_out_der(oder8), .cuenta(cuenta8), .listo(listo8)
  );

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    pruebas++;
    if (obs !== esp) begin
      fallos++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // One clock edge; returns 1 time unit after it so outputs are settled.
  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic carga4(input logic [3:0] v);
    reset4 = 1'b0; enb4 = 1'b1; modo4 = 2'b00; usual4 = v;
    paso();
  endtask

  logic [3:0] bits_piso;
  logic [3:0] bits_sipo;
  logic [7:0] palabra8;

  initial begin
    reset4 = 1'b0; enb4 = 1'b0; modo4 = 2'b00; usual4 = '0; sizq4 = 1'b0; sder4 = 1'b0;
    reset8 = 1'b1; enb8 = 1'b0; modo8 = 2'b00; usual8 = '0; sizq8 = 1'b0; sder8 = 1'b0;
    #2;

    // 1: reset wins over a load
    reset4 = 1'b1; enb4 = 1'b1; modo4 = 2'b00; usual4 = 4'b1111;
    paso();
    chequear("rst_q", 32'(q4), 32'h0);
    chequear("rst_cuenta", 32'(cuenta4), 32'h0);
    chequear("rst_listo", 32'(listo4), 32'h0);
    carga4(4'b1010);
    chequear("load_q", 32'(q4), 32'hA);
    chequear("load_cuenta", 32'(cuenta4), 32'h0);

    // 2: PISO right shift, s_out_der sampled before each edge
    carga4(4'b1011);
    chequear("piso_oizq", 32'(oizq4), 32'h1);
    bits_piso = 4'b1011;
    modo4 = 2'b10; sizq4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chequear($sformatf("piso_bit%0d", i), 32'(oder4), 32'(bits_piso[i]));
      if (i == 3) chequear("piso_listo_pre", 32'(listo4), 32'h0);
      paso();
    end
    chequear("piso_q", 32'(q4), 32'h0);
    chequear("piso_cuenta", 32'(cuenta4), 32'h4);
    chequear("piso_listo", 32'(listo4), 32'h1);
    paso();
    chequear("piso_saturacion", 32'(cuenta4), 32'h4);

    // 3: SIPO left shift from reset
    reset4 = 1'b1; paso(); reset4 = 1'b0;
    bits_sipo = 4'b1001;
    modo4 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      sder4 = bits_sipo[3-i];
      paso();
    end
    chequear("sipo_q", 32'(q4), 32'h9);
    chequear("sipo_listo", 32'(listo4), 32'h1);
    carga4(4'b0110);
    chequear("sipo_load_q", 32'(q4), 32'h6);
    chequear("sipo_load_cuenta", 32'(cuenta4), 32'h0);
    chequear("sipo_load_listo", 32'(listo4), 32'h0);

    // 4: enable low and modo 11 with a non-zero count
    carga4(4'b0011);
    modo4 = 2'b01; sder4 = 1'b0;
    paso(); paso();
    chequear("hold_pre_q", 32'(q4), 32'hC);
    chequear("hold_pre_cuenta", 32'(cuenta4), 32'h2);
    enb4 = 1'b0; modo4 = 2'b01; sder4 = 1'b1; usual4 = 4'b0101;
    repeat (3) paso();
    chequear("enb0_q", 32'(q4), 32'hC);
    chequear("enb0_cuenta", 32'(cuenta4), 32'h2);
    enb4 = 1'b1; modo4 = 2'b11; sder4 = 1'b1;
    paso();
`ifdef ROTACION_EN
    chequear("modo11_q", 32'(q4), 32'h9);
    chequear("modo11_cuenta", 32'(cuenta4), 32'h3);
`else
    chequear("modo11_q", 32'(q4), 32'hC);
    chequear("modo11_cuenta", 32'(cuenta4), 32'h2);
`endif

`ifdef ROTACION_EN
    // 5: rotation left then right
    carga4(4'b1000);
    modo4 = 2'b11; sder4 = 1'b1; sizq4 = 1'b1;
    paso();
    chequear("rotl_q", 32'(q4), 32'h1);
    chequear("rotl_cuenta", 32'(cuenta4), 32'h1);
    sder4 = 1'b0;
    paso();
    chequear("rotr_q", 32'(q4), 32'h8);
    chequear("rotr_cuenta", 32'(cuenta4), 32'h2);
`endif

    // 6: reset mid-word discards partial shifts
    carga4(4'b1111);
    modo4 = 2'b10; sizq4 = 1'b0;
    paso(); paso();
    chequear("mid_q", 32'(q4), 32'h3);
    chequear("mid_cuenta", 32'(cuenta4), 32'h2);
    reset4 = 1'b1; modo4 = 2'b10;
    paso();
    chequear("mid_rst_q", 32'(q4), 32'h0);
    chequear("mid_rst_cuenta", 32'(cuenta4), 32'h0);

    // reset also wins over enb low
    carga4(4'b0101);
    reset4 = 1'b1; enb4 = 1'b0;
    paso();
    chequear("rst_enb0_q", 32'(q4), 32'h0);
    reset4 = 1'b0; enb4 = 1'b1;

    // 6b: N=8 PISO of A5
    paso();
    reset8 = 1'b0; enb8 = 1'b1; modo8 = 2'b00; usual8 = 8'hA5;
    paso();
    chequear("n8_load_q", 32'(q8), 32'hA5);
    chequear("n8_oizq", 32'(oizq8), 32'h1);
    palabra8 = 8'hA5;
    modo8 = 2'b10; sizq8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chequear($sformatf("n8_bit%0d", i), 32'(oder8), 32'(palabra8[i]));
      paso();
      if (i == 6) chequear("n8_listo_7", 32'(listo8), 32'h0);
    end
    chequear("n8_q", 32'(q8), 32'h0);
    chequear("n8_cuenta", 32'(cuenta8), 32'h8);
    chequear("n8_listo", 32'(listo8), 32'h1);
    paso();
    chequear("n8_saturacion", 32'(cuenta8), 32'h8);

    $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
    $finish;
  end

endmodule

// File: doc/registro_universal_n.md
Name: registro_universal_n

Overview:
- Parametrised N-bit universal shift register.
- Generalises the per-bit serial/contiguous mode-select cell into a complete clocked register with:
  - parallel load;
  - left and right shifting, with a separate serial input per direction;
  - hold or rotate;
  - a shift counter that flags when a full word has been serialised.
- Sits between parallel datapath logic and serial links (SIPO/PISO use).

Parameters:
- N, 4, register width in bits; N >= 2.
- CW, $clog2(N+1), width of the shift counter. Derived; not overridden by users.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  clock enable. 0 = every register holds, including cuenta.
- modo  input  2  operation select (see Behaviour).
- usual  input  N  parallel load data.
- s_in_izq  input  1  serial input entering the MSB on a right shift.
- s_in_der  input  1  serial input entering the LSB on a left shift.
- q  output  N  register contents.
- s_out_izq  output  1  equals q[N-1] (combinational from q).
- s_out_der  output  1  equals q[0] (combinational from q).
- cuenta  output  CW  number of shifts since the last load or reset, saturating at N.
- listo  output  1  high while cuenta == N.

Behaviour:
- All state updates only on the rising edge of clk. No asynchronous paths.
- Priority per edge: reset > enb == 0 > modo.
- Reset:
  - q = 0, cuenta = 0, listo = 0.
  - Takes effect on the edge where reset is sampled high, regardless of enb or modo.
  - A reset in the middle of a shift sequence discards the partial word.
- enb == 0: q and cuenta are unchanged; modo and the data inputs are ignored.
- modo 00, parallel load:
  - q <= usual.
  - cuenta <= 0.
- modo 01, shift left:
  - q <= {q[N-2:0], s_in_der}.
  - Bit shifted out is the old q[N-1], visible on s_out_izq before the edge.
- modo 10, shift right:
  - q <= {s_in_izq, q[N-1:1]}.
  - Bit shifted out is the old q[0], visible on s_out_der before the edge.
- modo 11: hold, or rotate when the optional feature is compiled in (see Optional Feature).
- cuenta:
  - Increments by 1 on every enabled shift: modo 01, modo 10, and modo 11 when it rotates.
  - Saturates at N; never wraps.
  - A mixed sequence of left and right shifts counts each shift.
- listo: combinational from cuenta (listo = cuenta == N), so it rises in the same cycle cuenta reaches N.
- Load with enb == 1 in the cycle after listo clears cuenta; listo drops on that edge.
- Latency: a single-cycle operation. q reflects the operation on the edge after the inputs are sampled.
- Inputs are assumed stable around the clk edge. No internal synchronisers.

Optional Feature:
- Macro: ROTACION_EN.
- Defined: modo 11 rotates.
  - Direction is selected by s_in_der: 1 = rotate left, q <= {q[N-2:0], q[N-1]}; 0 = rotate right, q <= {q[0], q[N-1:1]}.
  - s_in_izq is ignored in modo 11.
  - Each rotation increments cuenta (saturating).
- Undefined: modo 11 holds q and cuenta unchanged, identical to enb == 0.

Test Plan (N=4 unless noted):
1. Reset with enb=1 and modo=00, usual=1111 -> q=0000, cuenta=0, listo=0 after the edge. Release reset, load 1010 -> q=1010, cuenta=0.
2. PISO: load 1011, then 4 cycles of modo=10 with s_in_izq=0 -> s_out_der sequence before each edge is 1,1,0,1. Final q=0000, cuenta=4, listo=1. A 5th shift keeps cuenta=4.
3. SIPO: from reset, 4 cycles of modo=01 with s_in_der = 1,0,0,1 -> q=1001, listo=1. Load usual=0110 -> q=0110, cuenta=0, listo=0.
4. Enable and hold: q=1100, enb=0, modo=01 for 3 cycles -> q=1100, cuenta unchanged. Then enb=1, modo=11 without ROTACION_EN -> q=1100.
5. ROTACION_EN defined, q=1000: modo=11, s_in_der=1 -> q=0001, cuenta=1. Next modo=11, s_in_der=0 -> q=1000, cuenta=2.
6. Reset mid-word: load 1111, two right shifts (q=0011, cuenta=2), assert reset with modo=10 -> q=0000, cuenta=0. Repeat test 2 with N=8, usual=8'hA5 -> serial bits 1,0,1,0,0,1,0,1 and listo after 8 shifts.
